// File: rtl/circuit3_signature_analyzer.sv
// circuit3_signature_analyzer: serial-input signature register (SISR) compacting
//   circuit3's z output over NUM_PATTERNS accepted bits, then checking against GOLDEN_SIG.
// Latency: done/pass are valid one cycle after the last accepted bit; each bit costs one valid cycle.
// Backpressure: none; z_valid gaps of any length stall the run without losing state.
// Optional feature: define FAULT_INJECT_EN to add fi_en/fi_val, which force z (stuck-at) on every accepted bit.
module circuit3_signature_analyzer #(
  parameter int               SIG_W        = 16,
  parameter logic [SIG_W-1:0] POLY         = 16'h1021,
  parameter logic [SIG_W-1:0] SEED         = 16'h0000,
  parameter int               NUM_PATTERNS = 32,
  parameter logic [SIG_W-1:0] GOLDEN_SIG   = 16'h0000,
  localparam int              CNT_W        = $clog2(NUM_PATTERNS + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             z_in,
  input  logic             z_valid,
`ifdef FAULT_INJECT_EN
  input  logic             fi_en,
  input  logic             fi_val,
`endif
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [SIG_W-1:0] signature,
  output logic [CNT_W-1:0] pattern_cnt
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // Count value held while the final bit of a run is being accepted.
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_PATTERNS - 1);

  state_t           r_state;
  logic             r_busy;
  logic             r_done;
  logic             r_pass;
  logic [SIG_W-1:0] r_sig;
  logic [CNT_W-1:0] r_cnt;

  logic             w_z_eff;
  logic             w_fb;
  logic [SIG_W-1:0] w_sig_next;
  logic             w_last;

`ifdef FAULT_INJECT_EN
  // Stuck-at override of z, sampled every cycle.
  assign w_z_eff = fi_en ? fi_val : z_in;
`else
  assign w_z_eff = z_in;
`endif

  // SISR step: shift left, fold the outgoing MSB with the incoming bit into the taps.
  assign w_fb       = r_sig[SIG_W-1] ^ w_z_eff;
  assign w_sig_next = {r_sig[SIG_W-2:0], 1'b0} ^ (w_fb ? POLY : {SIG_W{1'b0}});
  assign w_last     = (r_cnt == LAST_CNT);

  // Run controller: IDLE -> RUN on start, RUN -> DONE on the last accepted bit, DONE -> IDLE.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_pass  <= 1'b0;
      r_sig   <= SEED;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_done <= 1'b0;
          // z_valid in the start cycle is deliberately not absorbed.
          if (start) begin
            r_state <= S_RUN;
            r_busy  <= 1'b1;
            r_sig   <= SEED;
            r_cnt   <= '0;
            r_pass  <= 1'b0;
          end
        end
        S_RUN: begin
          if (z_valid) begin
            r_sig <= w_sig_next;
            r_cnt <= r_cnt + CNT_W'(1);
            if (w_last) begin
              // Verdict is taken on the final signature so it lines up with done.
              r_state <= S_DONE;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
              r_pass  <= (w_sig_next == GOLDEN_SIG);
            end
          end
        end
        S_DONE: begin
          // One-cycle pulse; signature, pass and count stay frozen afterwards.
          r_state <= S_IDLE;
          r_done  <= 1'b0;
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign busy        = r_busy;
  assign done        = r_done;
  assign pass        = r_pass;
  assign signature   = r_sig;
  assign pattern_cnt = r_cnt;

endmodule

// File: tb/tb_circuit3_signature_analyzer.sv
// Directed bench for circuit3_signature_analyzer with NUM_PATTERNS=4, SEED=0,
// POLY=16'h1021, GOLDEN_SIG=16'h8108; expected signatures are hand-computed.
// Fault-injection steps are compiled in only when FAULT_INJECT_EN is defined.
module tb_circuit3_signature_analyzer;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        z_in;
  logic        z_valid;
`ifdef FAULT_INJECT_EN
  logic        fi_en;
  logic        fi_val;
`endif
  logic        busy;
  logic        done;
  logic        pass;
  logic [15:0] signature;
  logic [2:0]  pattern_cnt;

  int n_checks = 0;
  int n_pass   = 0;

  circuit3_signature_analyzer #(
    .SIG_W       (16),
    .POLY        (16'h1021),
    .SEED        (16'h0000),
    .NUM_PATTERNS(4),
    .GOLDEN_SIG  (16'h8108)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .z_in       (z_in),
    .z_valid    (z_valid),
`ifdef FAULT_INJECT_EN
    .fi_en      (fi_en),
    .fi_val     (fi_val),
`endif
    .busy       (busy),
    .done       (done),
    .pass       (pass),
    .signature  (signature),
    .pattern_cnt(pattern_cnt)
  );

  always #5 clk = ~clk;

  // Advance one rising edge, then settle before sampling/driving.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Compare every output against its expected value.
  task automatic chk(input string tag, input logic e_busy, input logic e_done,
                     input logic e_pass, input logic [15:0] e_sig, input logic [2:0] e_cnt);
    n_checks++;
    assert (busy === e_busy) n_pass++;
    else begin
      $display("FAIL %s.busy observed=%0h expected=%0h", tag, busy, e_busy);
      $error("%s.busy observed=%0h expected=%0h", tag, busy, e_busy);
    end
    n_checks++;
    assert (done === e_done) n_pass++;
    else begin
      $display("FAIL %s.done observed=%0h expected=%0h", tag, done, e_done);
      $error("%s.done observed=%0h expected=%0h", tag, done, e_done);
    end
    n_checks++;
    assert (pass === e_pass) n_pass++;
    else begin
      $display("FAIL %s.pass observed=%0h expected=%0h", tag, pass, e_pass);
      $error("%s.pass observed=%0h expected=%0h", tag, pass, e_pass);
    end
    n_checks++;
    assert (signature === e_sig) n_pass++;
    else begin
      $display("FAIL %s.sig observed=%04h expected=%04h", tag, signature, e_sig);
      $error("%s.sig observed=%04h expected=%04h", tag, signature, e_sig);
    end
    n_checks++;
    assert (pattern_cnt === e_cnt) n_pass++;
    else begin
      $display("FAIL %s.cnt observed=%0d expected=%0d", tag, pattern_cnt, e_cnt);
      $error("%s.cnt observed=%0d expected=%0d", tag, pattern_cnt, e_cnt);
    end
  endtask

  // Drive one input vector for a single clock edge.
  task automatic drive(input logic s, input logic v, input logic z);
    start   = s;
    z_valid = v;
    z_in    = z;
    tick();
  endtask

  initial begin
    // Reset held with busy inputs: reset must win.
    rst = 1'b1; start = 1'b1; z_valid = 1'b1; z_in = 1'b1;
`ifdef FAULT_INJECT_EN
    fi_en = 1'b0; fi_val = 1'b0;
`endif
    tick();
    tick();
    chk("reset", 0, 0, 0, 16'h0000, 3'd0);
    rst = 1'b0;
    drive(0, 0, 0);
    chk("idle", 0, 0, 0, 16'h0000, 3'd0);

    // Basic run 1,0,0,0.
    drive(1, 0, 0); chk("t2.start", 1, 0, 0, 16'h0000, 3'd0);
    drive(0, 1, 1); chk("t2.b1",    1, 0, 0, 16'h1021, 3'd1);
    drive(0, 1, 0); chk("t2.b2",    1, 0, 0, 16'h2042, 3'd2);
    drive(0, 1, 0); chk("t2.b3",    1, 0, 0, 16'h4084, 3'd3);
    drive(0, 1, 0); chk("t2.b4",    0, 1, 1, 16'h8108, 3'd4);
    drive(0, 0, 0); chk("t2.after", 0, 0, 1, 16'h8108, 3'd4);

    // Same stream with gaps, valid data in the start cycle, and start pulsed mid-run.
    drive(1, 1, 1); chk("t3.start", 1, 0, 0, 16'h0000, 3'd0);
    drive(0, 0, 1); chk("t3.gap0",  1, 0, 0, 16'h0000, 3'd0);
    drive(0, 1, 1); chk("t3.b1",    1, 0, 0, 16'h1021, 3'd1);
    drive(1, 0, 1); chk("t3.restart", 1, 0, 0, 16'h1021, 3'd1);
    drive(0, 1, 0); chk("t3.b2",    1, 0, 0, 16'h2042, 3'd2);
    drive(0, 0, 1); chk("t3.gap1",  1, 0, 0, 16'h2042, 3'd2);
    drive(0, 0, 1); chk("t3.gap2",  1, 0, 0, 16'h2042, 3'd2);
    drive(0, 1, 0); chk("t3.b3",    1, 0, 0, 16'h4084, 3'd3);
    drive(0, 1, 0); chk("t3.b4",    0, 1, 1, 16'h8108, 3'd4);
    drive(0, 0, 0); chk("t3.after", 0, 0, 1, 16'h8108, 3'd4);

    // All-zero stream fails; bits after done are not absorbed.
    drive(1, 0, 0); chk("t4.start", 1, 0, 0, 16'h0000, 3'd0);
    drive(0, 1, 0); chk("t4.b1",    1, 0, 0, 16'h0000, 3'd1);
    drive(0, 1, 0); chk("t4.b2",    1, 0, 0, 16'h0000, 3'd2);
    drive(0, 1, 0); chk("t4.b3",    1, 0, 0, 16'h0000, 3'd3);
    drive(0, 1, 0); chk("t4.b4",    0, 1, 0, 16'h0000, 3'd4);
    drive(0, 1, 1); chk("t4.extra1", 0, 0, 0, 16'h0000, 3'd4);
    drive(0, 1, 1); chk("t4.extra2", 0, 0, 0, 16'h0000, 3'd4);

    // Reset mid-run aborts without done; a fresh run still passes.
    drive(1, 0, 0); chk("t5.start", 1, 0, 0, 16'h0000, 3'd0);
    drive(0, 1, 1); chk("t5.b1",    1, 0, 0, 16'h1021, 3'd1);
    drive(0, 1, 0); chk("t5.b2",    1, 0, 0, 16'h2042, 3'd2);
    rst = 1'b1;
    drive(0, 1, 0); chk("t5.rst",   0, 0, 0, 16'h0000, 3'd0);
    rst = 1'b0;
    drive(0, 1, 0); chk("t5.idle",  0, 0, 0, 16'h0000, 3'd0);
    drive(1, 0, 0); chk("t5.start2", 1, 0, 0, 16'h0000, 3'd0);
    drive(0, 1, 1); chk("t5.c1",    1, 0, 0, 16'h1021, 3'd1);
    drive(0, 1, 0); chk("t5.c2",    1, 0, 0, 16'h2042, 3'd2);
    drive(0, 1, 0); chk("t5.c3",    1, 0, 0, 16'h4084, 3'd3);
    drive(0, 1, 0); chk("t5.c4",    0, 1, 1, 16'h8108, 3'd4);
    drive(0, 0, 0); chk("t5.after", 0, 0, 1, 16'h8108, 3'd4);

`ifdef FAULT_INJECT_EN
    // Stuck-at-0 on z: signature never leaves zero.
    fi_en = 1'b1; fi_val = 1'b0;
    drive(1, 0, 0); chk("t6.s0.start", 1, 0, 0, 16'h0000, 3'd0);
    drive(0, 1, 1); chk("t6.s0.b1",    1, 0, 0, 16'h0000, 3'd1);
    drive(0, 1, 0); chk("t6.s0.b2",    1, 0, 0, 16'h0000, 3'd2);
    drive(0, 1, 0); chk("t6.s0.b3",    1, 0, 0, 16'h0000, 3'd3);
    drive(0, 1, 0); chk("t6.s0.b4",    0, 1, 0, 16'h0000, 3'd4);
    drive(0, 0, 0);
    // Stuck-at-1 on z.
    fi_val = 1'b1;
    drive(1, 0, 0); chk("t6.s1.start", 1, 0, 0, 16'h0000, 3'd0);
    drive(0, 1, 1); chk("t6.s1.b1",    1, 0, 0, 16'h1021, 3'd1);
    drive(0, 1, 0); chk("t6.s1.b2",    1, 0, 0, 16'h3063, 3'd2);
    drive(0, 1, 0); chk("t6.s1.b3",    1, 0, 0, 16'h70E7, 3'd3);
    drive(0, 1, 0); chk("t6.s1.b4",    0, 1, 0, 16'hF1EF, 3'd4);
    fi_en = 1'b0;
    drive(0, 0, 0); chk("t6.after",    0, 0, 0, 16'hF1EF, 3'd4);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
